// File: rtl/rca_config_loader_pkg.sv
// Shared types and sizing for the RCA config loader.
// Widths derive from the RCA count and per-RCA slot counts.
package rca_config_loader_pkg;

    localparam int NUM_RCAS        = 4;
    localparam int NUM_READ_PORTS  = 3;
    localparam int NUM_WRITE_PORTS = 2;
    localparam int REG_ADDR_W      = 5;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int RCA_ID_W       = $clog2(NUM_RCAS);
    localparam int RCA_PORT_SEL_W =
        $clog2(max_int(NUM_READ_PORTS, NUM_WRITE_PORTS));

    typedef struct packed {
        logic [RCA_ID_W-1:0]                         id;
        logic [NUM_READ_PORTS-1:0][REG_ADDR_W-1:0]   src_addrs;
        logic [NUM_READ_PORTS-1:0]                   src_mask;
        logic [NUM_WRITE_PORTS-1:0][REG_ADDR_W-1:0]  dest_addrs;
        logic [NUM_WRITE_PORTS-1:0]                  dest_mask;
    } rca_cfg_desc_t;

    typedef enum logic [1:0] {
        LOAD_IDLE,
        LOAD_WRITE_SRC,
        LOAD_WRITE_DEST,
        LOAD_DONE
    } rca_cfg_load_state_t;

endpackage

// File: rtl/rca_config_loader.sv
// Serializes one RCA descriptor into single-slot config writes.
// Owns the shared rca_sel mux and stalls issue while writing.
module rca_config_loader
    import rca_config_loader_pkg::*;
(
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       cfg_valid,
    output logic                                       cfg_ready,
    input  logic [RCA_ID_W-1:0]                        cfg_rca_id,
    input  logic [NUM_READ_PORTS-1:0][REG_ADDR_W-1:0]  cfg_src_addrs,
    input  logic [NUM_READ_PORTS-1:0]                  cfg_src_mask,
    input  logic [NUM_WRITE_PORTS-1:0][REG_ADDR_W-1:0] cfg_dest_addrs,
    input  logic [NUM_WRITE_PORTS-1:0]                 cfg_dest_mask,
    output logic                                       cfg_done,
    output logic [RCA_ID_W-1:0]                        cfg_done_rca_id,
    input  logic [RCA_ID_W-1:0]                        issue_rca_sel,
    output logic                                       issue_stall,
    output logic [RCA_ID_W-1:0]                        rca_sel,
    output logic                                       wr_en,
    output logic [RCA_PORT_SEL_W-1:0]                  w_port_sel,
    output logic                                       w_src_dest_port,
    output logic [REG_ADDR_W-1:0]                      w_reg_addr
);

    localparam logic [RCA_PORT_SEL_W-1:0] LAST_SRC =
        RCA_PORT_SEL_W'(NUM_READ_PORTS - 1);
    localparam logic [RCA_PORT_SEL_W-1:0] LAST_DEST =
        RCA_PORT_SEL_W'(NUM_WRITE_PORTS - 1);

    rca_cfg_load_state_t         state_q, state_d;
    logic [RCA_PORT_SEL_W-1:0]   idx_q, idx_d;
    rca_cfg_desc_t               desc_q, desc_d;
    logic                        writing;

    assign writing = (state_q == LOAD_WRITE_SRC) ||
                     (state_q == LOAD_WRITE_DEST);

    // Next-state: accept in idle, walk src slots, then dest slots, then done.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        desc_d  = desc_q;
        unique case (state_q)
            LOAD_IDLE: begin
                if (cfg_valid) begin
                    desc_d.id         = cfg_rca_id;
                    desc_d.src_addrs  = cfg_src_addrs;
                    desc_d.src_mask   = cfg_src_mask;
                    desc_d.dest_addrs = cfg_dest_addrs;
                    desc_d.dest_mask  = cfg_dest_mask;
                    idx_d             = '0;
                    state_d           = LOAD_WRITE_SRC;
                end
            end
            LOAD_WRITE_SRC: begin
                if (idx_q == LAST_SRC) begin
                    idx_d   = '0;
                    state_d = LOAD_WRITE_DEST;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            LOAD_WRITE_DEST: begin
                if (idx_q == LAST_DEST) begin
                    idx_d   = '0;
                    state_d = LOAD_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            LOAD_DONE: begin
                state_d = LOAD_IDLE;
            end
        endcase
    end

    // Write port and handshake decode from registered state only.
    always_comb begin
        cfg_ready       = 1'b0;
        cfg_done        = 1'b0;
        wr_en           = 1'b0;
        w_src_dest_port = 1'b0;
        w_reg_addr      = '0;
        w_port_sel      = idx_q;
        unique case (state_q)
            LOAD_IDLE: begin
                cfg_ready = 1'b1;
            end
            LOAD_WRITE_SRC: begin
                for (int i = 0; i < NUM_READ_PORTS; i++) begin
                    if (idx_q == RCA_PORT_SEL_W'(i)) begin
                        wr_en      = desc_q.src_mask[i];
                        w_reg_addr = desc_q.src_addrs[i];
                    end
                end
            end
            LOAD_WRITE_DEST: begin
                w_src_dest_port = 1'b1;
                for (int i = 0; i < NUM_WRITE_PORTS; i++) begin
                    if (idx_q == RCA_PORT_SEL_W'(i)) begin
                        wr_en      = desc_q.dest_mask[i];
                        w_reg_addr = desc_q.dest_addrs[i];
                    end
                end
            end
            LOAD_DONE: begin
                cfg_done = 1'b1;
            end
        endcase
    end

    assign cfg_done_rca_id = desc_q.id;
    assign issue_stall     = writing;
    assign rca_sel         = writing ? desc_q.id : issue_rca_sel;

    // State, slot index and latched descriptor; reset abandons any load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= LOAD_IDLE;
            idx_q   <= '0;
            desc_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            desc_q  <= desc_d;
        end
    end

endmodule
